branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Parametrised branch unit: direct-mapped BHT of 2-bit saturating counters plus tagged BTB
//  for fetch-side prediction. Resolves all six RV32I conditional branches from ALU flags at execute.
//  Issues a one-cycle registered redirect on mispredict. Sits between IF (predict port) and EX (resolve port).
// PARAMETERS
//  XLEN       32  address/immediate width
//  IDX_BITS    6  log2 table entries (64); index = pc[IDX_BITS+1:2]
//  TAG_BITS    8  BTB tag width; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
//  CNT_W      32  width of statistics counters
// PORTS
//  clk             in   1        rising-edge clock
//  reset           in   1        asynchronous, active-high
//  pred_pc         in   XLEN     fetch PC to predict
//  pred_taken      out  1        predicted taken (hit AND counter[1])
//  pred_target     out  XLEN     predicted target; pred_pc+4 when not taken
//  res_valid       in   1        EX holds a resolvable instruction this cycle
//  res_branch      in   1        instruction is a conditional branch
//  res_func3       in   3        branch type
//  res_zero        in   1        ALU zero flag
//  res_negative    in   1        ALU signed-less-than flag
//  res_ltu         in   1        ALU unsigned-less-than flag
//  res_pc          in   XLEN     PC of resolving instruction
//  res_imm         in   XLEN     sign-extended B-immediate
//  res_pred_taken  in   1        prediction carried down pipe
//  res_pred_target in   XLEN     predicted target carried down pipe
//  redirect        out  1        mispredict flush, registered
//  redirect_pc     out  XLEN     correct next PC, registered
//  stat_branches   out  CNT_W    resolved branches, saturating
//  stat_mispredict out  CNT_W    mispredicts, saturating
// BEHAVIOUR
//  - Reset (async, active-high): all valid bits 0, all counters 2'b01 (weakly not-taken),
//    redirect=0, redirect_pc=0, both stat counters 0. Reset mid-resolve drops the resolve.
//  - Predict: combinational read of registered tables, zero latency. Miss (valid=0 or tag
//    mismatch) -> pred_taken=0, pred_target=pred_pc+4.
//  - Condition: 000 BEQ=zero, 001 BNE=~zero, 100 BLT=negative, 101 BGE=~negative,
//    110 BLTU=ltu, 111 BGEU=~ltu. 010/011 = not a branch: no update, no stats, no redirect.
//  - Resolve (res_valid & res_branch & legal func3): actual target = res_pc+res_imm, mod 2^XLEN.
//    mispredict = (taken != res_pred_taken) | (taken & res_pred_target != target).
//    Next edge: redirect=mispredict; redirect_pc = taken ? target : res_pc+4. redirect is high
//    exactly one cycle per mispredict; back-to-back mispredicts give back-to-back pulses.
//  - Update same edge: counter +1 if taken, -1 if not; saturates at 2'b11 and 2'b00 (no wrap).
//    Taken: write tag, target, valid=1. Not taken on tag miss: counter and BTB untouched.
//  - Simultaneous predict and update of same index: predict returns pre-update value.
//  - Stats: stat_branches +1 per legal resolve; stat_mispredict +1 per mispredict;
//    both hold at all-ones.
//  - res_valid=0 or res_branch=0: tables, stats unchanged; redirect=0 next cycle.
// STRUCTURE
//  - Package branch_pkg: func3 constants (F3_BEQ..F3_BGEU), counter encodings
//    (SNT=00, WNT=01, WT=10, ST=11), helper for index/tag slicing.
//  - Sub-module branch_cond_eval: combinational func3+flags -> taken, legal.
//  - Tables as flop arrays (async reset requires flops, not RAM).
// TESTING
//  1 Reset then pred_pc=0x100 -> pred_taken=0, pred_target=0x104; stats 0; redirect 0.
//  2 Resolve BEQ pc=0x100 imm=0x40 zero=1, pred_taken=0 -> next cycle redirect=1,
//    redirect_pc=0x140; then pred_pc=0x100 -> pred_taken=1, pred_target=0x140.
//  3 Four taken resolves at 0x100 then three not-taken -> counter 11,11,11,10,01,00:
//    prediction flips to not-taken after second not-taken; no wrap at either end.
//  4 All six func3 with flags (z,n,ltu) = (1,0,0),(0,1,1),(0,0,0) -> taken matches table;
//    func3=010 -> no redirect, stat_branches unchanged.
//  5 Alias: 0x100 and 0x100+(1<<(IDX_BITS+2)) -> tag miss predicts not-taken;
//    taken resolve on alias overwrites entry.
//  6 Assert reset during cycle with mispredicting resolve -> redirect stays 0, tables cleared;
//    force stat_mispredict to all-ones -> further mispredict holds value.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared constants and helpers for the branch prediction unit.
// Holds the RV32I conditional-branch func3 codes, the 2-bit counter encodings,
// PC field slicing for table index/tag, and the saturating counter step.
package branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  // Extract `bits` bits of pc starting at `lsb`; callers size-cast the result.
  function automatic logic [63:0] pc_field(logic [63:0] pc, int unsigned lsb, int unsigned bits);
    return (pc >> lsb) & ((64'd1 << bits) - 64'd1);
  endfunction
  // One step of a 2-bit saturating counter; never wraps at either end.
  function automatic logic [1:0] sat_cnt(logic [1:0] c, logic up);
    return up ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: evaluates an RV32I conditional branch from ALU flags.
// Ports: func3 (branch type), zero/negative/ltu (ALU flags) -> taken, legal.
// func3 010/011 are not branches: legal=0 and taken=0.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       negative,
  input  logic       ltu,
  output logic       taken,
  output logic       legal
);
  logic base;
  // func3[2:1] selects the flag, func3[0] inverts it (BNE/BGE/BGEU).
  assign legal = (func3 != 3'b010) && (func3 != 3'b011);
  assign base  = func3[2] ? (func3[1] ? ltu : negative) : zero;
  assign taken = legal & (base ^ func3[0]);
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BHT (2-bit counters) plus tagged BTB.
// Predict port (IF): pred_pc -> pred_taken, pred_target (combinational).
// Resolve port (EX): res_* inputs -> registered redirect/redirect_pc on mispredict,
// table update, saturating stat_branches/stat_mispredict counters.
// reset is asynchronous active-high; tables are flop arrays so they can be cleared.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             res_valid,
  input  logic             res_branch,
  input  logic [2:0]       res_func3,
  input  logic             res_zero,
  input  logic             res_negative,
  input  logic             res_ltu,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [XLEN-1:0]  res_imm,
  input  logic             res_pred_taken,
  input  logic [XLEN-1:0]  res_pred_target,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredict
);
  localparam int ENTRIES = 1 << IDX_BITS;
  logic [1:0]          cnt [ENTRIES];
  logic                vld [ENTRIES];
  logic [TAG_BITS-1:0] tag [ENTRIES];
  logic [XLEN-1:0]     tgt [ENTRIES];
  logic [IDX_BITS-1:0] p_idx, r_idx;
  logic [TAG_BITS-1:0] p_tag, r_tag;
  logic                p_hit, r_hit, taken, legal, do_res, mis;
  logic [XLEN-1:0]     target;
  assign p_idx = IDX_BITS'(pc_field(64'(pred_pc), 2, IDX_BITS));
  assign p_tag = TAG_BITS'(pc_field(64'(pred_pc), IDX_BITS + 2, TAG_BITS));
  assign r_idx = IDX_BITS'(pc_field(64'(res_pc), 2, IDX_BITS));
  assign r_tag = TAG_BITS'(pc_field(64'(res_pc), IDX_BITS + 2, TAG_BITS));
  // Predict reads the registered tables, so a same-cycle update is not visible yet.
  assign p_hit       = vld[p_idx] && (tag[p_idx] == p_tag);
  assign pred_taken  = p_hit & cnt[p_idx][1];
  assign pred_target = pred_taken ? tgt[p_idx] : pred_pc + XLEN'(4);
  branch_cond_eval u_cond (
    .func3    (res_func3),
    .zero     (res_zero),
    .negative (res_negative),
    .ltu      (res_ltu),
    .taken    (taken),
    .legal    (legal)
  );
  assign r_hit  = vld[r_idx] && (tag[r_idx] == r_tag);
  assign do_res = res_valid & res_branch & legal;
  assign target = res_pc + res_imm;
  assign mis    = (taken != res_pred_taken) | (taken & (res_pred_target != target));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt[i] <= WNT;
        vld[i] <= 1'b0;
        tag[i] <= '0;
        tgt[i] <= '0;
      end
      redirect        <= 1'b0;
      redirect_pc     <= '0;
      stat_branches   <= '0;
      stat_mispredict <= '0;
    end else begin
      redirect <= do_res & mis;
      if (do_res) begin
        redirect_pc     <= taken ? target : res_pc + XLEN'(4);
        // Adding zero once all-ones gives saturation without a compare-and-mux.
        stat_branches   <= stat_branches + CNT_W'(~&stat_branches);
        stat_mispredict <= stat_mispredict + CNT_W'(mis & ~&stat_mispredict);
        if (taken) begin
          cnt[r_idx] <= sat_cnt(cnt[r_idx], 1'b1);
          vld[r_idx] <= 1'b1;
          tag[r_idx] <= r_tag;
          tgt[r_idx] <= target;
        end else if (r_hit) begin
          cnt[r_idx] <= sat_cnt(cnt[r_idx], 1'b0);
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed self-checking bench for branch_predict_unit.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid, res_branch, res_zero, res_negative, res_ltu, res_pred_taken;
  logic [2:0]  res_func3;
  logic [31:0] res_pc, res_imm, res_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [4:0]  stat_branches, stat_mispredict;
  int checks = 0;
  int errors = 0;

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .TAG_BITS(8), .CNT_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_branch      (res_branch),
    .res_func3       (res_func3),
    .res_zero        (res_zero),
    .res_negative    (res_negative),
    .res_ltu         (res_ltu),
    .res_pc          (res_pc),
    .res_imm         (res_imm),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .stat_branches   (stat_branches),
    .stat_mispredict (stat_mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  task automatic predict(input string t, input logic [31:0] pc, input logic et, input logic [31:0] etg);
    pred_pc = pc;
    #1;
    chk({t, "_taken"}, 32'(pred_taken), 32'(et));
    chk({t, "_target"}, pred_target, etg);
  endtask

  task automatic resolve(input logic [2:0] f3, input logic z, input logic n, input logic l,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptg);
    res_valid = 1'b1; res_branch = 1'b1; res_func3 = f3;
    res_zero = z; res_negative = n; res_ltu = l;
    res_pc = pc; res_imm = imm; res_pred_taken = pt; res_pred_target = ptg;
    @(posedge clk);
    #1;
    res_valid = 1'b0; res_branch = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] f3s [6];
  logic [2:0] flg [3];
  logic       exp_tk [3][6];

  initial begin
    f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    flg = '{3'b100, 3'b011, 3'b000};
    exp_tk = '{'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
               '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}};
    reset = 1'b1; pred_pc = 32'h100;
    res_valid = 0; res_branch = 0; res_func3 = 0; res_zero = 0; res_negative = 0;
    res_ltu = 0; res_pc = 0; res_imm = 0; res_pred_taken = 0; res_pred_target = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // reset state
    predict("rst_pred", 32'h100, 1'b0, 32'h104);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_stat_br", 32'(stat_branches), 32'd0);
    chk("rst_stat_mis", 32'(stat_mispredict), 32'd0);
    // first taken BEQ: mispredict, BTB fill, counter 01->10
    resolve(3'b000, 1, 0, 0, 32'h100, 32'h40, 0, 32'h0);
    chk("beq_redirect", 32'(redirect), 32'd1);
    chk("beq_redirect_pc", redirect_pc, 32'h140);
    chk("beq_stat_br", 32'(stat_branches), 32'd1);
    chk("beq_stat_mis", 32'(stat_mispredict), 32'd1);
    predict("beq_pred", 32'h100, 1'b1, 32'h140);
    idle();
    chk("pulse_one_cycle", 32'(redirect), 32'd0);
    // four correctly predicted takens: counter saturates at 11
    for (int i = 0; i < 4; i++) begin
      resolve(3'b000, 1, 0, 0, 32'h100, 32'h40, 1, 32'h140);
      chk("tk_no_redirect", 32'(redirect), 32'd0);
    end
    chk("tk_stat_br", 32'(stat_branches), 32'd5);
    chk("tk_stat_mis", 32'(stat_mispredict), 32'd1);
    // not-taken run: 11->10 still taken, 10->01 flips
    resolve(3'b000, 0, 0, 0, 32'h100, 32'h40, 1, 32'h140);
    chk("nt1_redirect", 32'(redirect), 32'd1);
    chk("nt1_redirect_pc", redirect_pc, 32'h104);
    predict("nt1_pred", 32'h100, 1'b1, 32'h140);
    resolve(3'b000, 0, 0, 0, 32'h100, 32'h40, 1, 32'h140);
    chk("nt2_back_to_back", 32'(redirect), 32'd1);
    predict("nt2_pred", 32'h100, 1'b0, 32'h104);
    resolve(3'b000, 0, 0, 0, 32'h100, 32'h40, 0, 32'h0);
    resolve(3'b000, 0, 0, 0, 32'h100, 32'h40, 0, 32'h0);
    chk("nt_correct_no_redirect", 32'(redirect), 32'd0);
    predict("nt4_pred", 32'h100, 1'b0, 32'h104);
    // floor held at 00: one taken -> 01 (not taken), second -> 10 (taken)
    resolve(3'b000, 1, 0, 0, 32'h100, 32'h40, 0, 32'h0);
    predict("up1_pred", 32'h100, 1'b0, 32'h104);
    resolve(3'b000, 1, 0, 0, 32'h100, 32'h40, 0, 32'h0);
    predict("up2_pred", 32'h100, 1'b1, 32'h140);
    chk("run_stat_br", 32'(stat_branches), 32'd11);
    chk("run_stat_mis", 32'(stat_mispredict), 32'd5);
    // all six conditions over three flag sets, always predicted not-taken
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 6; j++) begin
        resolve(f3s[j], flg[k][2], flg[k][1], flg[k][0], 32'h80, 32'h20, 0, 32'h0);
        chk($sformatf("cond_f3_%0d_set%0d", f3s[j], k), 32'(redirect), 32'(exp_tk[k][j]));
        if (exp_tk[k][j]) chk("cond_redirect_pc", redirect_pc, 32'hA0);
      end
    end
    chk("cond_stat_br", 32'(stat_branches), 32'd29);
    chk("cond_stat_mis", 32'(stat_mispredict), 32'd14);
    // illegal func3 and non-branch: nothing happens
    resolve(3'b010, 1, 1, 1, 32'h80, 32'h20, 1, 32'h0);
    chk("f3_010_redirect", 32'(redirect), 32'd0);
    resolve(3'b011, 0, 0, 0, 32'h80, 32'h20, 1, 32'h0);
    chk("f3_011_redirect", 32'(redirect), 32'd0);
    res_branch = 1'b0; res_valid = 1'b1; res_func3 = 3'b000; res_zero = 1'b1;
    res_pred_taken = 1'b0;
    idle();
    res_valid = 1'b0;
    chk("nonbranch_redirect", 32'(redirect), 32'd0);
    chk("illegal_stat_br", 32'(stat_branches), 32'd29);
    chk("illegal_stat_mis", 32'(stat_mispredict), 32'd14);
    // aliasing at index 0: 0x200 has tag 2, entry holds tag 1 for 0x100
    predict("alias_miss", 32'h200, 1'b0, 32'h204);
    resolve(3'b000, 0, 0, 0, 32'h200, 32'h10, 0, 32'h0);
    predict("alias_nt_untouched", 32'h100, 1'b1, 32'h140);
    resolve(3'b000, 1, 0, 0, 32'h200, 32'h10, 0, 32'h0);
    chk("alias_redirect_pc", redirect_pc, 32'h210);
    predict("alias_new", 32'h200, 1'b1, 32'h210);
    predict("alias_old_evicted", 32'h100, 1'b0, 32'h104);
    chk("alias_stat_br", 32'(stat_branches), 32'd31);
    // saturate stat_mispredict: 15 -> 31 takes 16 mispredicts
    for (int i = 0; i < 16; i++) resolve(3'b000, 0, 0, 0, 32'h40, 32'h8, 1, 32'h48);
    chk("sat_stat_br", 32'(stat_branches), 32'd31);
    chk("sat_stat_mis", 32'(stat_mispredict), 32'd31);
    resolve(3'b000, 0, 0, 0, 32'h40, 32'h8, 1, 32'h48);
    chk("sat_hold_redirect", 32'(redirect), 32'd1);
    chk("sat_hold_mis", 32'(stat_mispredict), 32'd31);
    chk("sat_hold_br", 32'(stat_branches), 32'd31);
    // reset during a mispredicting resolve drops it and clears tables
    res_valid = 1'b1; res_branch = 1'b1; res_func3 = 3'b000; res_zero = 1'b1;
    res_pc = 32'h200; res_imm = 32'h10; res_pred_taken = 1'b0; res_pred_target = 32'h0;
    reset = 1'b1;
    idle();
    chk("rstmid_redirect", 32'(redirect), 32'd0);
    chk("rstmid_stat_br", 32'(stat_branches), 32'd0);
    chk("rstmid_stat_mis", 32'(stat_mispredict), 32'd0);
    res_valid = 1'b0; res_branch = 1'b0;
    reset = 1'b0;
    predict("rstmid_pred", 32'h200, 1'b0, 32'h204);
    idle();
    chk("rstmid_after_redirect", 32'(redirect), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
